// File: rtl/seven_segment_scanner_if.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner_if
//
// Bundles the frame-load handshake and the multiplexed display pins of
// seven_segment_scanner.
//
//   load       valid: digits_in holds a new frame
//   digits_in  4*NUM_DIGITS bits, digit i in [4i+3:4i], digit 0 rightmost
//   ready      scanner can accept a new frame into its shadow register
//   led_out    7 active-high segments, bit0 = top, bit6 = middle
//   digit_en   one-hot active-high digit select
//   frame_done one-cycle pulse at the end of each frame
//
// Modports:
//   master - the producer of frames / consumer of display pins (e.g. a bench
//            or the counter logic plus board pins)
//   slave  - the scanner itself
// -----------------------------------------------------------------------------
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    ready;
  logic [6:0]              led_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  modport master (
    output load,
    output digits_in,
    input  ready,
    input  led_out,
    input  digit_en,
    input  frame_done
  );

  modport slave (
    input  load,
    input  digits_in,
    output ready,
    output led_out,
    output digit_en,
    output frame_done
  );

endinterface

// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexes NUM_DIGITS hex/BCD digits onto one shared 7-segment bus.
// Each digit is preceded by BLANK_COUNT cycles with everything dark (to avoid
// ghosting when the digit select changes) and then lit for SCAN_COUNT cycles.
// New frames arrive through a valid/ready handshake into a shadow register
// and are copied into the displayed (active) register only at a frame
// boundary, so a frame is never a mix of old and new digits.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset (synchronously released upstream)
//   enable   scan enable; low forces the display dark and restarts scanning
//   bus      seven_segment_scanner_if.slave: load/digits_in/ready handshake,
//            led_out, digit_en, frame_done (all outputs registered)
//
// Parameters:
//   NUM_DIGITS  number of multiplexed digits (1..8)
//   SCAN_COUNT  cycles each digit is lit (>= 1)
//   BLANK_COUNT cycles of dark gap before each digit (>= 1)
//
// Optional feature macro: HEX_DECODE_EN
//   defined   - codes 10..15 show A, b, C, d, E, F
//   undefined - codes 10..15 show blank
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_COUNT  = 16000,
  parameter int BLANK_COUNT = 160
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  seven_segment_scanner_if.slave        bus
);

  localparam int MAX_COUNT = (SCAN_COUNT > BLANK_COUNT) ? SCAN_COUNT : BLANK_COUNT;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W    = 4 * NUM_DIGITS;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Segment decode, bit6..bit0 = g f e d c b a (bit0 top, bit6 middle).
  function automatic logic [6:0] seg7_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7C;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h67;
`ifdef HEX_DECODE_EN
      4'd10:   seg = 7'h77;
      4'd11:   seg = 7'h7C;
      4'd12:   seg = 7'h39;
      4'd13:   seg = 7'h5E;
      4'd14:   seg = 7'h79;
      4'd15:   seg = 7'h71;
`endif
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Scan control
  state_t                state_q,      state_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic [IDX_W-1:0]      idx_q,        idx_d;

  // Frame storage and handshake
  logic [DATA_W-1:0]     active_q,     active_d;
  logic [DATA_W-1:0]     shadow_q,     shadow_d;
  logic                  pending_q,    pending_d;
  logic                  ready_q,      ready_d;

  // Registered outputs
  logic [6:0]            led_out_q,    led_out_d;
  logic [NUM_DIGITS-1:0] digit_en_q,   digit_en_d;
  logic                  frame_done_q, frame_done_d;

  logic                  blank_end;
  logic                  show_end;
  logic                  last_digit;
  logic                  boundary;
  logic                  accept;
  logic [3:0]            cur_code;

  assign blank_end  = (cnt_q == CNT_W'(BLANK_COUNT - 1));
  assign show_end   = (cnt_q == CNT_W'(SCAN_COUNT - 1));
  assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign accept     = bus.load && ready_q;
  assign cur_code   = active_q[{idx_q, 2'b00} +: 4];

  // ---------------------------------------------------------------------------
  // Scan FSM: next state, counters and the output values registered this edge
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    led_out_d    = 7'h00;
    digit_en_d   = '0;
    frame_done_d = 1'b0;
    boundary     = 1'b0;

    if (!enable) begin
      // Park at the start of a frame so re-enabling begins with digit 0's gap.
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (blank_end) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_SHOW: begin
          led_out_d  = seg7_decode(cur_code);
          digit_en_d = NUM_DIGITS'(1) << idx_q;
          if (show_end) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (last_digit) begin
              idx_d        = '0;
              frame_done_d = 1'b1;
              boundary     = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load handshake and frame-boundary update of the displayed digits
  // ---------------------------------------------------------------------------
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ready_d   = ready_q;

    // Uses the pre-edge pending flag, so a load accepted on the boundary
    // cycle itself waits for the next boundary. While dark there is no frame
    // to tear, so a pending frame is applied straight away.
    if (pending_q && (boundary || !enable)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      ready_d   = 1'b1;
    end

    // ready_q is low whenever pending_q is high, so this never collides with
    // the update above.
    if (accept) begin
      shadow_d  = bus.digits_in;
      pending_d = 1'b1;
      ready_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
      led_out_q    <= 7'h00;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
      led_out_q    <= led_out_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ready      = ready_q;
  assign bus.led_out    = led_out_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Scoreboard bench for seven_segment_scanner with NUM_DIGITS=4, SCAN_COUNT=10,
// BLANK_COUNT=2. The stimulus process drives one cycle at a time, predicts the
// pin values after the coming clock edge from a frame-position model and
// queues them; a monitor process pops one entry after every rising edge and
// compares.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

  localparam int N     = 4;
  localparam int S     = 10;
  localparam int B     = 2;
  localparam int PER   = B + S;
  localparam int FRAME = N * PER;

  typedef struct packed {
    logic [6:0] led;
    logic [3:0] den;
    logic       fd;
    logic       rdy;
  } exp_t;

  logic clk;
  logic reset_n;
  logic enable;

  seven_segment_scanner_if #(.NUM_DIGITS(N)) bus ();

  seven_segment_scanner #(
    .NUM_DIGITS (N),
    .SCAN_COUNT (S),
    .BLANK_COUNT(B)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  exp_t q[$];

  // Reference model state
  int          en_cnt;     // enabled edges since scanning (re)started, mod FRAME
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pending;
  bit          last_fd;

  logic [6:0] seg_tab [16];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    en_cnt    = 0;
    m_active  = 16'h0;
    m_shadow  = 16'h0;
    m_pending = 1'b0;
    last_fd   = 1'b0;
  endtask

  // Drive one cycle (called just after a falling edge), predict the pins
  // after the next rising edge, then move to the next falling edge.
  task automatic cycle(input bit en, input bit ld, input logic [15:0] din);
    exp_t e;
    int   s, d, r;
    bit   apply, acc;
    enable        = en;
    bus.load      = ld;
    bus.digits_in = din;
    e     = '0;
    acc   = ld && !m_pending;
    apply = 1'b0;
    if (en) begin
      s = en_cnt;
      d = s / PER;
      r = s % PER;
      if (r >= B) begin
        e.den = 4'(1 << d);
        e.led = seg_tab[(m_active >> (4 * d)) & 16'hF];
      end
      e.fd   = (s == FRAME - 1);
      apply  = m_pending && (s == FRAME - 1);
      en_cnt = (en_cnt + 1) % FRAME;
    end else begin
      en_cnt = 0;
      apply  = m_pending;
    end
    if (apply) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    if (acc) begin
      m_shadow  = din;
      m_pending = 1'b1;
    end
    e.rdy   = !m_pending;
    last_fd = e.fd;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0);
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("led_out",    int'(bus.led_out),    int'(e.led));
        chk("digit_en",   int'(bus.digit_en),   int'(e.den));
        chk("frame_done", int'(bus.frame_done), int'(e.fd));
        chk("ready",      int'(bus.ready),      int'(e.rdy));
      end
    end
  end

  initial begin
    bit done2;
    int guard;

    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7C; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h67;
`ifdef HEX_DECODE_EN
    seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C; seg_tab[12] = 7'h39;
    seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;
`else
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h00;
`endif

    reset_n       = 1'b0;
    enable        = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = 16'h0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_led_out",    int'(bus.led_out),    0);
    chk("rst_digit_en",   int'(bus.digit_en),   0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
    chk("rst_ready",      int'(bus.ready),      1);
    reset_n = 1'b1;

    // Free-running scan of an all-zero frame
    cycle(1'b0, 1'b0, 16'h0);
    idle(60);

    // Mid-frame load, then a held load ignored while busy, then 5678
    cycle(1'b1, 1'b1, 16'h1234);
    done2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!done2) begin
        if (m_pending) cycle(1'b1, 1'b1, 16'h9999);
        else begin
          cycle(1'b1, 1'b1, 16'h5678);
          done2 = 1'b1;
        end
      end else cycle(1'b1, 1'b0, 16'h0);
    end

    // Load on the frame_done cycle
    guard = 0;
    while (!last_fd && guard < 100) begin
      cycle(1'b1, 1'b0, 16'h0);
      guard++;
    end
    chk("wait_frame_done_1", int'(last_fd), 1);
    cycle(1'b1, 1'b1, 16'h4321);
    idle(110);

    // Pending load, then enable dropped during digit 2's lit window
    guard = 0;
    while (!last_fd && guard < 100) begin
      cycle(1'b1, 1'b0, 16'h0);
      guard++;
    end
    cycle(1'b1, 1'b1, 16'h0987);
    guard = 0;
    while (!((en_cnt / PER == 2) && (en_cnt % PER == B + 4)) && guard < 100) begin
      cycle(1'b1, 1'b0, 16'h0);
      guard++;
    end
    chk("reach_digit2", en_cnt / PER, 2);
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h2468);   // accepted while dark: applied next cycle
    cycle(1'b0, 1'b0, 16'h0);
    idle(60);

    // Hex codes
    cycle(1'b1, 1'b1, 16'hFEDA);
    idle(110);

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0), 16'($urandom));

    // Async reset in the middle of a lit window with a load pending
    idle(3);
    cycle(1'b1, 1'b1, 16'h7777);
    guard = 0;
    while (!((en_cnt % PER) >= B + 2 && (en_cnt % PER) < PER - 1) && guard < 100) begin
      cycle(1'b1, 1'b0, 16'h0);
      guard++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_led_out",    int'(bus.led_out),    0);
    chk("arst_digit_en",   int'(bus.digit_en),   0);
    chk("arst_frame_done", int'(bus.frame_done), 0);
    chk("arst_ready",      int'(bus.ready),      1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    idle(110);

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
